// File: rtl/maskd_pkg.sv
// ============================================================================
// Module  : maskd_pkg
// Purpose : Shared mode encoding and constants for the mask-decode pipeline.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package maskd_pkg;

    typedef enum logic [1:0] {
        LEFT_INCL  = 2'd0,
        LEFT_EXCL  = 2'd1,
        RIGHT_INCL = 2'd2,
        RIGHT_EXCL = 2'd3
    } mode_e;

    localparam int ERR_CNT_W = 16;

    function automatic mode_e mode_of(input bit incl, input bit left);
        if (left) begin
            return incl ? LEFT_INCL : LEFT_EXCL;
        end
        return incl ? RIGHT_INCL : RIGHT_EXCL;
    endfunction

endpackage

`default_nettype wire

// File: rtl/maskd_enc.sv
// ============================================================================
// Module  : maskd_enc
// Purpose : Combinational contiguous-mask to index decoder with legality flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module maskd_enc
    import maskd_pkg::*;
#(
    parameter int    W    = 8,
    parameter mode_e MODE = LEFT_INCL,
    localparam int   X_W  = $clog2(W)
) (
    input  logic [W-1:0]   y,
    output logic [X_W-1:0] x,
    output logic           err
);

    logic [X_W-1:0] w_lsb;
    logic [X_W-1:0] w_msb;
    logic [W-1:0]   w_regen;

    always_comb begin
        w_lsb = '0;
        w_msb = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (y[i]) w_lsb = X_W'(i);
        end
        for (int i = 0; i < W; i++) begin
            if (y[i]) w_msb = X_W'(i);
        end
    end

    // Out-of-range candidates (lsb-1 below 0, msb+1 at W) collapse to 0.
    always_comb begin
        x = '0;
        case (MODE)
            LEFT_INCL: x = w_lsb;
            LEFT_EXCL: begin
                if (y == '0)          x = X_W'(W - 1);
                else if (w_lsb != '0) x = w_lsb - X_W'(1);
            end
            RIGHT_INCL: x = w_msb;
            RIGHT_EXCL: begin
                if (y != '0 && int'(w_msb) < W - 1) x = w_msb + X_W'(1);
            end
            default: x = '0;
        endcase
    end

    // A mask is legal exactly when it regenerates from its own decoded index.
    always_comb begin
        w_regen = '0;
        for (int i = 0; i < W; i++) begin
            case (MODE)
                LEFT_INCL:  w_regen[i] = (i >= int'(x));
                LEFT_EXCL:  w_regen[i] = (i >  int'(x));
                RIGHT_INCL: w_regen[i] = (i <= int'(x));
                default:    w_regen[i] = (i <  int'(x));
            endcase
        end
    end

    assign err = (y != w_regen);

endmodule

`default_nettype wire

// File: rtl/maskd_pipe.sv
// ============================================================================
// Module  : maskd_pipe
// Purpose : Two-stage valid/ready pipeline recovering an index from its mask.
//           Optional error counter output enabled by MASKD_PIPE_ERR_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module maskd_pipe
    import maskd_pkg::*;
#(
    parameter int  W              = 8,
    parameter bit  P_INCLUSIVE    = 1'b0,
    parameter bit  LEFT_NOT_RIGHT = 1'b1,
    localparam int X_W            = $clog2(W)
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 in_vld_i,
    input  logic [W-1:0]         in_y_i,
    output logic                 in_rdy_o,
    output logic                 out_vld_o,
    output logic [X_W-1:0]       out_x_o,
    output logic                 out_err_o,
    input  logic                 out_rdy_i
`ifdef MASKD_PIPE_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt_o
`endif
);

    localparam mode_e c_MODE = mode_of(P_INCLUSIVE, LEFT_NOT_RIGHT);

    logic           r_s1_vld;
    logic [W-1:0]   r_s1_y;
    logic           r_s2_vld;
    logic [X_W-1:0] r_s2_x;
    logic           r_s2_err;
    logic           w_s1_rdy;
    logic           w_s2_rdy;
    logic [X_W-1:0] w_dec_x;
    logic           w_dec_err;

    assign w_s2_rdy = !r_s2_vld || out_rdy_i;
    assign w_s1_rdy = !r_s1_vld || w_s2_rdy;
    assign in_rdy_o = w_s1_rdy;

    always_ff @(posedge clk) begin
        if (in_vld_i && w_s1_rdy) r_s1_y <= in_y_i;
    end

    maskd_enc #(
        .W    (W),
        .MODE (c_MODE)
    ) u_enc (
        .y   (r_s1_y),
        .x   (w_dec_x),
        .err (w_dec_err)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
            r_s2_x   <= '0;
            r_s2_err <= 1'b0;
        end else begin
            if (w_s1_rdy) r_s1_vld <= in_vld_i;
            if (w_s2_rdy) begin
                r_s2_vld <= r_s1_vld;
                if (r_s1_vld) begin
                    r_s2_x   <= w_dec_x;
                    r_s2_err <= w_dec_err;
                end
            end
        end
    end

    assign out_vld_o = r_s2_vld;
    assign out_x_o   = r_s2_x;
    assign out_err_o = r_s2_err;

`ifdef MASKD_PIPE_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_err_cnt <= '0;
        end else if (out_vld_o && out_rdy_i && out_err_o && r_err_cnt != '1) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end

    assign err_cnt_o = r_err_cnt;
`else
    // Error counting disabled: no extra state.
`endif

endmodule

`default_nettype wire

// File: tb/tb_maskd_pipe.sv
// ============================================================================
// Module  : tb_maskd_pipe
// Purpose : Randomized self-checking bench, all four modes at W=8 and W=5.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_maskd_pipe;

    logic             clk = 1'b0;
    logic             arst;
    logic             in_vld;
    logic [7:0]       in_y;
    logic             out_rdy;
    logic [7:0]       rdy_v;
    logic [7:0]       vld_v;
    logic [7:0]       err_v;
    logic [7:0][2:0]  x_v;
`ifdef MASKD_PIPE_ERR_CNT_EN
    logic [7:0][15:0] cnt_v;
`endif

    int n_chk = 0;
    int n_err = 0;
    int n_edge = 0;
    logic [7:0] hist_y[$];
    int         hist_e[$];
    int         cnt_exp[8];

    always #5 clk = ~clk;

    // Instances 0..3: W=8 modes LI, LE, RI, RE; instances 4..7: same at W=5.
    for (genvar m = 0; m < 4; m++) begin : g_w8
        maskd_pipe #(
            .W              (8),
            .P_INCLUSIVE    (m == 0 || m == 2),
            .LEFT_NOT_RIGHT (m < 2)
        ) u_dut (
            .clk       (clk),
            .arst      (arst),
            .in_vld_i  (in_vld),
            .in_y_i    (in_y),
            .in_rdy_o  (rdy_v[m]),
            .out_vld_o (vld_v[m]),
            .out_x_o   (x_v[m]),
            .out_err_o (err_v[m]),
            .out_rdy_i (out_rdy)
`ifdef MASKD_PIPE_ERR_CNT_EN
            ,
            .err_cnt_o (cnt_v[m])
`endif
        );
    end

    for (genvar m = 0; m < 4; m++) begin : g_w5
        maskd_pipe #(
            .W              (5),
            .P_INCLUSIVE    (m == 0 || m == 2),
            .LEFT_NOT_RIGHT (m < 2)
        ) u_dut (
            .clk       (clk),
            .arst      (arst),
            .in_vld_i  (in_vld),
            .in_y_i    (in_y[4:0]),
            .in_rdy_o  (rdy_v[m+4]),
            .out_vld_o (vld_v[m+4]),
            .out_x_o   (x_v[m+4]),
            .out_err_o (err_v[m+4]),
            .out_rdy_i (out_rdy)
`ifdef MASKD_PIPE_ERR_CNT_EN
            ,
            .err_cnt_o (cnt_v[m+4])
`endif
        );
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Mask produced by the generator for index x (mode 0=LI,1=LE,2=RI,3=RE).
    function automatic int gen(input int x, input int mode, input int w);
        int m = 0;
        for (int i = 0; i < w; i++) begin
            bit b;
            case (mode)
                0:       b = (i >= x);
                1:       b = (i >  x);
                2:       b = (i <= x);
                default: b = (i <  x);
            endcase
            if (b) m = m | (1 << i);
        end
        return m;
    endfunction

    // Returns x in bits [7:0] and the error flag in bit 8.
    function automatic int model(input int y, input int mode, input int w);
        int lsb = -1;
        int msb = -1;
        int rx;
        for (int x = 0; x < w; x++) begin
            if (gen(x, mode, w) == y) return x;
        end
        for (int i = w - 1; i >= 0; i--) if (((y >> i) & 1) != 0) lsb = i;
        for (int i = 0; i < w; i++)      if (((y >> i) & 1) != 0) msb = i;
        case (mode)
            0:       rx = (y == 0) ? 0 : lsb;
            1:       rx = (lsb <= 0) ? 0 : lsb - 1;
            2:       rx = (y == 0) ? 0 : msb;
            default: rx = (msb + 1 <= w - 1) ? msb + 1 : 0;
        endcase
        return rx | 256;
    endfunction

    function automatic int expect_for(input int k, input logic [7:0] y);
        int w = (k < 4) ? 8 : 5;
        int yy = (k < 4) ? int'(y) : (int'(y) & 31);
        return model(yy, k % 4, w);
    endfunction

    task automatic check_idle_outputs(input string phase);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s vld k%0d", phase, k), int'(vld_v[k]), 0);
            chk($sformatf("%s rdy k%0d", phase, k), int'(rdy_v[k]), 1);
            chk($sformatf("%s x k%0d", phase, k), int'(x_v[k]), 0);
            chk($sformatf("%s err k%0d", phase, k), int'(err_v[k]), 0);
`ifdef MASKD_PIPE_ERR_CNT_EN
            chk($sformatf("%s cnt k%0d", phase, k), int'(cnt_v[k]), 0);
`endif
        end
    endtask

    task automatic run_cycle(input bit v, input logic [7:0] y, input bit r);
        bit exp_rdy;
        bit exp_vld;
        int e;
        @(negedge clk);
        in_vld  = v;
        in_y    = y;
        out_rdy = r;
        #1;
        exp_rdy = (hist_y.size() < 2) || r;
        exp_vld = (hist_y.size() > 0) && (n_edge >= hist_e[0] + 1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("in_rdy k%0d", k), int'(rdy_v[k]), int'(exp_rdy));
            chk($sformatf("out_vld k%0d", k), int'(vld_v[k]), int'(exp_vld));
            if (exp_vld) begin
                e = expect_for(k, hist_y[0]);
                chk($sformatf("out_x k%0d y=%02h", k, hist_y[0]), int'(x_v[k]), e & 255);
                chk($sformatf("out_err k%0d y=%02h", k, hist_y[0]), int'(err_v[k]), e >> 8);
            end
`ifdef MASKD_PIPE_ERR_CNT_EN
            chk($sformatf("err_cnt k%0d", k), int'(cnt_v[k]), cnt_exp[k]);
`endif
        end
        @(posedge clk);
        n_edge++;
        if (exp_vld && r) begin
            for (int k = 0; k < 8; k++) begin
                if ((expect_for(k, hist_y[0]) >> 8) != 0 && cnt_exp[k] < 65535) cnt_exp[k]++;
            end
            void'(hist_y.pop_front());
            void'(hist_e.pop_front());
        end
        if (v && exp_rdy) begin
            hist_y.push_back(y);
            hist_e.push_back(n_edge);
        end
    endtask

    initial begin
        logic [7:0] y;
        arst    = 1'b1;
        in_vld  = 1'b0;
        in_y    = '0;
        out_rdy = 1'b0;
        for (int k = 0; k < 8; k++) cnt_exp[k] = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        arst = 1'b0;

        // Directed masks, full throughput.
        run_cycle(1'b1, 8'b1111_1000, 1'b1);
        run_cycle(1'b1, 8'h00, 1'b1);
        run_cycle(1'b1, 8'h7F, 1'b1);
        run_cycle(1'b1, 8'b1011_0000, 1'b1);
        run_cycle(1'b1, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 8'h00, 1'b1);

        // Every 8-bit pattern back to back (covers all legal masks, both widths).
        for (int i = 0; i < 256; i++) run_cycle(1'b1, 8'(i), 1'b1);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 8'h00, 1'b1);

        // Backpressure: three masks offered while downstream stalls.
        run_cycle(1'b1, 8'hF0, 1'b0);
        run_cycle(1'b1, 8'h0F, 1'b0);
        run_cycle(1'b1, 8'h3C, 1'b0);
        run_cycle(1'b1, 8'h3C, 1'b0);
        for (int i = 0; i < 5; i++) run_cycle(1'b0, 8'h00, 1'b1);

        // Randomized traffic mixing legal masks and arbitrary patterns.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 1) == 0) y = 8'($urandom);
            else y = 8'(gen($urandom_range(0, 7), $urandom_range(0, 3), 8));
            run_cycle($urandom_range(0, 3) != 0, y, $urandom_range(0, 3) != 0);
        end

        // Asynchronous reset with both stages full.
        run_cycle(1'b1, 8'hFF, 1'b0);
        run_cycle(1'b1, 8'h01, 1'b0);
        run_cycle(1'b1, 8'h55, 1'b0);
        @(negedge clk);
        in_vld = 1'b0;
        arst   = 1'b1;
        #1;
        check_idle_outputs("midreset");
        hist_y.delete();
        hist_e.delete();
        for (int k = 0; k < 8; k++) cnt_exp[k] = 0;
        @(negedge clk);
        arst = 1'b0;
        for (int i = 0; i < 4; i++) run_cycle(1'b0, 8'h00, 1'b1);
        run_cycle(1'b1, 8'b1100_0000, 1'b1);
        for (int i = 0; i < 4; i++) run_cycle(1'b0, 8'h00, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
